// File: rtl/phase_seq_pkg.sv
// Shared definitions for the phase sequencer: sequencer states and the
// widths of the phase index and completed-cycle counter.
package phase_seq_pkg;

    // Width of the binary phase index output (covers up to 8 phases).
    localparam int PHASE_IDX_W = 3;

    // Width of the completed CPU cycle counter; wraps silently.
    localparam int CYC_CNT_W = 16;

    // Sequencer states.
    //   IDLE    : no phase active, waiting for run or a step request
    //   RUN     : free-running CPU cycles
    //   HALTING : stop requested, finishing the current cycle
    //   STEP    : executing exactly one CPU cycle, then back to IDLE
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALTING = 2'd2,
        STEP    = 2'd3
    } state_t;

endpackage : phase_seq_pkg

// File: rtl/phase_seq_edge_sync.sv
// edge_sync: brings the asynchronous divided clock into the clk domain
// through a SYNC_STAGES-deep flop chain, then turns each rising edge of
// the synchronised level into a single-clk tick.
//
// Timing: a rise on din sampled at clk edge n shows up as tick between
// edges n+SYNC_STAGES-1 and n+SYNC_STAGES, so a consumer registering on
// tick changes state SYNC_STAGES+1 edges after the rise.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchroniser chain plus one history flop for edge detection; all
    // cleared by reset so a level already high at release yields a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state is always assigned with <= so every
            // flop samples the pre-edge value of its neighbour.
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Rising edge of the synchronised level; both operands are flops.
    assign tick = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule : edge_sync

// File: rtl/phase_seq.sv
// phase_seq: instruction phase sequencer. Each rising edge of the
// divided clock (after synchronisation) advances a one-hot phase strobe;
// NPHASE phases make one CPU cycle. Supports free run, halting at the
// next cycle boundary and, optionally, single-cycle stepping.
//
// Build option: define PHASE_SEQ_STEP_EN to enable the STEP state,
// step_req and step_ack. Without it step_req is ignored and step_ack is
// tied low; the port list is identical in both builds.
module phase_seq
    import phase_seq_pkg::*;
#(
    parameter int NPHASE      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clkdiv,
    input  logic                   run,
    input  logic                   halt_req,
    input  logic                   step_req,
    output logic                   step_ack,
    output logic [NPHASE-1:0]      phase,
    output logic [PHASE_IDX_W-1:0] phase_idx,
    output logic                   cycle_start,
    output logic                   halted,
    output logic [CYC_CNT_W-1:0]   cycle_cnt
);

    // Index of the final phase of a CPU cycle.
    localparam logic [PHASE_IDX_W-1:0] LAST_IDX = PHASE_IDX_W'(NPHASE - 1);

    logic                   tick;
    state_t                 state_q, state_d;
    logic [PHASE_IDX_W-1:0] idx_q, idx_d;
    logic [CYC_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   cycle_start_q, cycle_start_d;
    logic                   stop_req;
    logic                   at_last;
    logic                   phase_on;

`ifdef PHASE_SEQ_STEP_EN
    // step_live: inside STEP, the first tick has started phase 0.
    logic                   step_live_q, step_live_d;
    logic                   step_ack_q, step_ack_d;
`else
    // step_req has no function in this build.
    logic                   unused_step_req;
    assign unused_step_req = step_req;
`endif

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk (clk),
        .rst (rst),
        .din (clkdiv),
        .tick(tick)
    );

    assign stop_req = halt_req | ~run;
    assign at_last  = (idx_q == LAST_IDX);

    // Next-state, phase index, cycle counter and pulse outputs.
    always_comb begin
        // NOTE: every variable gets a default first so no path through
        // the case statement can infer a latch.
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        cycle_start_d = 1'b0;
`ifdef PHASE_SEQ_STEP_EN
        step_live_d   = step_live_q;
        step_ack_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (tick && run && !halt_req) begin
                    state_d       = RUN;
                    cycle_start_d = 1'b1;
                end
`ifdef PHASE_SEQ_STEP_EN
                // run takes priority; a step request alongside it is dropped.
                else if (step_req && !run) begin
                    state_d     = STEP;
                    step_live_d = 1'b0;
                end
`endif
            end

            RUN: begin
                if (tick && at_last) begin
                    cnt_d = cnt_q + CYC_CNT_W'(1);
                    idx_d = '0;
                    if (stop_req) begin
                        // Stop landed exactly on the boundary: no new cycle.
                        state_d = IDLE;
                    end else begin
                        cycle_start_d = 1'b1;
                    end
                end else begin
                    if (tick) begin
                        idx_d = idx_q + PHASE_IDX_W'(1);
                    end
                    if (stop_req) begin
                        state_d = HALTING;
                    end
                end
            end

            HALTING: begin
                // run/halt_req are not looked at until back in IDLE.
                if (tick) begin
                    if (at_last) begin
                        cnt_d   = cnt_q + CYC_CNT_W'(1);
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + PHASE_IDX_W'(1);
                    end
                end
            end

`ifdef PHASE_SEQ_STEP_EN
            STEP: begin
                // All requests are ignored; only ticks move the step along.
                if (tick) begin
                    if (!step_live_q) begin
                        step_live_d   = 1'b1;
                        idx_d         = '0;
                        cycle_start_d = 1'b1;
                    end else if (at_last) begin
                        cnt_d       = cnt_q + CYC_CNT_W'(1);
                        idx_d       = '0;
                        step_live_d = 1'b0;
                        step_ack_d  = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d = idx_q + PHASE_IDX_W'(1);
                    end
                end
            end
`endif

            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State register with synchronous reset from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            cycle_start_q <= 1'b0;
`ifdef PHASE_SEQ_STEP_EN
            step_live_q   <= 1'b0;
            step_ack_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            cycle_start_q <= cycle_start_d;
`ifdef PHASE_SEQ_STEP_EN
            step_live_q   <= step_live_d;
            step_ack_q    <= step_ack_d;
`endif
        end
    end

    // A phase strobe is shown whenever a cycle is in progress; in STEP
    // that starts only once the first tick has opened phase 0.
`ifdef PHASE_SEQ_STEP_EN
    assign phase_on = (state_q != IDLE) && ((state_q != STEP) || step_live_q);
    assign step_ack = step_ack_q;
`else
    assign phase_on = (state_q != IDLE);
    assign step_ack = 1'b0;
`endif

    assign phase       = phase_on ? (NPHASE'(1) << idx_q) : '0;
    assign phase_idx   = idx_q;
    assign cycle_start = cycle_start_q;
    assign halted      = (state_q == IDLE);
    assign cycle_cnt   = cnt_q;

endmodule : phase_seq
